pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter INSTR_W, 32, instruction payload width in bits.
REQ-002 SHALL have parameter PC_W, 32, program-counter width in bits.
REQ-003 SHALL have parameter EXC_W, 5, exception-tag width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid  input  1, and in_ready  output  1: upstream handshake.
REQ-007 SHALL have ports in_instr  input  INSTR_W, in_pc  input  PC_W, in_exc  input  EXC_W, and in_bd  input  1 (delay-slot flag).
REQ-008 SHALL have port annul  input  1  drop the beat being accepted this cycle (likely-branch squash).
REQ-009 SHALL have port flush  input  1  synchronous clear of all entries (exception/eret).
REQ-010 SHALL have ports out_valid  output  1, and out_ready  input  1: downstream handshake.
REQ-011 SHALL have ports out_instr  output  INSTR_W, out_pc  output  PC_W, out_pc8  output  PC_W, out_exc  output  EXC_W, and out_bd  output  1.
REQ-012 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-013 SHALL hold two entries: main (drives outputs) and skid; states EMPTY, ONE (main only), TWO (main+skid).
REQ-014 SHALL drive in_ready = 1 exactly when state != TWO, decoded from registered state only (no combinational path from out_ready).
REQ-015 SHALL define accept = in_valid & in_ready and emit = out_valid & out_ready; out_valid = 1 exactly when state != EMPTY.
REQ-016 SHALL transition: EMPTY+store -> ONE (main<=in); ONE+store+emit -> ONE (main<=in); ONE+store, no emit -> TWO (skid<=in); ONE+emit, no store -> EMPTY; TWO+emit -> ONE (main<=skid); otherwise hold.
REQ-017 SHALL define store = accept & ~annul; an annulled accept completes the upstream handshake but writes nothing, and the state moves as if no beat arrived.
REQ-018 SHALL, when flush = 1, go to EMPTY and load bubble values into main and skid next edge, discarding any concurrent accept, annul, or emit; flush has priority over all other inputs.
REQ-019 SHALL use bubble values instr = 0, pc = all ones, exc = 0, bd = 0; out_* show main, which holds bubble values whenever state = EMPTY.
REQ-020 SHALL drive out_pc8 = out_pc + 8 modulo 2^PC_W when out_valid = 1, and 0 when out_valid = 0.
REQ-021 SHALL keep main and skid contents unchanged in any cycle with no store, no emit, and no flush (stall hold).
REQ-022 SHALL never drop or duplicate a non-annulled accepted beat and SHALL preserve FIFO order.
REQ-023 SHALL drive occupancy = 0/1/2 for EMPTY/ONE/TWO, registered.

Reset
REQ-024 SHALL, while reset = 0 and independent of clk, force state EMPTY, main and skid to bubble values, out_valid = 0, in_ready = 1, and occupancy = 0.
REQ-025 SHALL on reset assertion mid-operation discard all held entries; first accept is possible on the first rising edge after reset = 1.

Verification
REQ-026 SHALL cover: reset low, then high; in_valid = 1, in_pc = 0x00003000, out_ready = 1 -> next cycle out_valid = 1, out_pc = 0x00003000, out_pc8 = 0x00003008, occupancy = 1.
REQ-027 SHALL cover: out_ready = 0, two beats pc 0x3000 then 0x3004 -> occupancy = 2, in_ready = 0; out_ready = 1 -> outputs 0x3000 then 0x3004 in order.
REQ-028 SHALL cover: state ONE, accept with annul = 1, out_ready = 0 -> state stays ONE, out_pc unchanged, occupancy = 1.
REQ-029 SHALL cover: state TWO, flush = 1 with in_valid = 1 -> next cycle out_valid = 0, out_pc = 0xFFFFFFFF, out_instr = 0, out_pc8 = 0, occupancy = 0.
REQ-030 SHALL cover: reset asserted between clock edges while in state TWO -> outputs take bubble values immediately, before the next clk edge.
REQ-031 SHALL cover: PC_W = 16, in_pc = 0xFFFC -> out_pc8 = 0x0004 (wrap-around).

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Two-entry skid pipeline register for an instruction stage, with
//             annul (squash on accept) and flush (clear all entries).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  // upstream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  input  logic               annul,
  input  logic               flush,
  // downstream
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc8,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [1:0]         occupancy
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [EXC_W-1:0]   exc;
    logic               bd;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam entry_t          c_bubble  = '{instr: '0, pc: '1, exc: '0, bd: 1'b0};
  localparam logic [PC_W-1:0] c_pc_step = PC_W'(8);

  state_e state_q, state_d;
  entry_t main_q,  main_d;
  entry_t skid_q,  skid_d;

  logic   accept;
  logic   store;
  logic   emit;
  entry_t in_entry;

  assign in_entry = '{instr: in_instr, pc: in_pc, exc: in_exc, bd: in_bd};

  // Handshake flags come from registered state only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign store     = accept & ~annul;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = c_bubble;
      skid_d  = c_bubble;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (store) begin
            state_d = ST_ONE;
            main_d  = in_entry;
          end
        end
        ST_ONE: begin
          if (store && emit) begin
            main_d = in_entry;
          end else if (store) begin
            state_d = ST_TWO;
            skid_d  = in_entry;
          end else if (emit) begin
            state_d = ST_EMPTY;
            main_d  = c_bubble;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path can move.
          if (emit) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = c_bubble;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = c_bubble;
          skid_d  = c_bubble;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= c_bubble;
      skid_q  <= c_bubble;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign out_exc   = main_q.exc;
  assign out_bd    = main_q.bd;
  assign out_pc8   = out_valid ? (main_q.pc + c_pc_step) : '0;
  assign occupancy = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Directed self-checking bench for pipe_stage_reg (32- and 16-bit PC).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_exc;
  logic        in_bd;
  logic        annul;
  logic        flush;
  logic        out_ready;
  logic [15:0] in_pc16;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc8;
  logic [4:0]  out_exc;
  logic        out_bd;
  logic [1:0]  occupancy;

  logic        b_in_ready;
  logic        b_out_valid;
  logic [31:0] b_out_instr;
  logic [15:0] b_out_pc;
  logic [15:0] b_out_pc8;
  logic [4:0]  b_out_exc;
  logic        b_out_bd;
  logic [1:0]  b_occupancy;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(.INSTR_W(32), .PC_W(32), .EXC_W(5)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_exc    (in_exc),
    .in_bd     (in_bd),
    .annul     (annul),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pc8   (out_pc8),
    .out_exc   (out_exc),
    .out_bd    (out_bd),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(.INSTR_W(32), .PC_W(16), .EXC_W(5)) u_dut16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc16),
    .in_exc    (in_exc),
    .in_bd     (in_bd),
    .annul     (annul),
    .flush     (flush),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_instr (b_out_instr),
    .out_pc    (b_out_pc),
    .out_pc8   (b_out_pc8),
    .out_exc   (b_out_exc),
    .out_bd    (b_out_bd),
    .occupancy (b_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs/outputs are touched 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    in_pc16   = '0;
    in_exc    = '0;
    in_bd     = 1'b0;
    annul     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    #1 reset = 1'b0;
    #6;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'hFFFF_FFFF);
    chk("rst_out_pc8",   64'(out_pc8),   64'd0);

    // First beat after reset release.
    #5;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_3000;
    in_pc16   = 16'hFFFC;
    in_instr  = 32'h0000_0011;
    out_ready = 1'b1;
    tick();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_pc",    64'(out_pc),    64'h3000);
    chk("first_pc8",   64'(out_pc8),   64'h3008);
    chk("first_occ",   64'(occupancy), 64'd1);
    chk("first_instr", 64'(out_instr), 64'h11);
    chk("pc16_pc",     64'(b_out_pc),  64'hFFFC);
    chk("pc16_wrap",   64'(b_out_pc8), 64'h0004);

    in_valid = 1'b0;
    tick();
    chk("drain_occ",   64'(occupancy), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_pc",    64'(out_pc),    64'hFFFF_FFFF);

    // Fill both entries with the consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3000;
    in_instr  = 32'hA1;
    tick();
    in_pc    = 32'h3004;
    in_instr = 32'hA2;
    tick();
    chk("two_occ",      64'(occupancy), 64'd2);
    chk("two_in_ready", 64'(in_ready),  64'd0);
    chk("two_head_pc",  64'(out_pc),    64'h3000);

    // Offer a beat while full: it must not be taken until in_ready rises.
    in_pc     = 32'h5000;
    in_instr  = 32'hA3;
    out_ready = 1'b1;
    tick();
    chk("order_2nd_pc", 64'(out_pc),    64'h3004);
    chk("order_2nd_in", 64'(out_instr), 64'hA2);
    chk("order_occ",    64'(occupancy), 64'd1);
    chk("order_rdy",    64'(in_ready),  64'd1);
    tick();
    chk("order_3rd_pc", 64'(out_pc),    64'h5000);
    chk("order_3rd_oc", 64'(occupancy), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("order_empty",  64'(occupancy), 64'd0);

    // Annulled accept in state ONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h6000;
    in_instr  = 32'hB1;
    in_exc    = 5'h0A;
    in_bd     = 1'b1;
    tick();
    chk("exc_field", 64'(out_exc), 64'h0A);
    chk("bd_field",  64'(out_bd),  64'd1);
    in_pc    = 32'h6004;
    in_instr = 32'hB2;
    in_exc   = 5'h00;
    in_bd    = 1'b0;
    annul    = 1'b1;
    tick();
    chk("annul_occ", 64'(occupancy), 64'd1);
    chk("annul_pc",  64'(out_pc),    64'h6000);
    annul    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("stall_pc",  64'(out_pc),    64'h6000);
    chk("stall_occ", 64'(occupancy), 64'd1);

    // Flush from TWO with a concurrent beat offered and consumer ready.
    in_valid = 1'b1;
    in_pc    = 32'h6008;
    in_instr = 32'hB3;
    tick();
    chk("pre_flush_occ", 64'(occupancy), 64'd2);
    flush     = 1'b1;
    in_pc     = 32'h7000;
    out_ready = 1'b1;
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pc",    64'(out_pc),    64'hFFFF_FFFF);
    chk("flush_instr", 64'(out_instr), 64'd0);
    chk("flush_pc8",   64'(out_pc8),   64'd0);
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_exc",   64'(out_exc),   64'd0);
    chk("flush_bd",    64'(out_bd),    64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset between edges while full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h8000;
    in_instr  = 32'hC1;
    tick();
    in_pc    = 32'h8004;
    in_instr = 32'hC2;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_pc",    64'(out_pc),    64'hFFFF_FFFF);
    chk("arst_instr", 64'(out_instr), 64'd0);
    chk("arst_occ",   64'(occupancy), 64'd0);
    chk("arst_rdy",   64'(in_ready),  64'd1);
    #2 reset = 1'b1;

    in_valid = 1'b1;
    in_pc    = 32'h9000;
    in_instr = 32'hD1;
    tick();
    chk("post_rst_pc",  64'(out_pc),    64'h9000);
    chk("post_rst_occ", 64'(occupancy), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_drain", 64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
